div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multicycle signed integer divider for the processor's multdiv path. It is the inverse operation to the multiplier on the same `ctrl_`/`data_` interface.
- Accepts a one-cycle start pulse with two 32-bit operands.
- Produces one quotient bit per cycle using a restoring shift-subtract datapath, then pulses `data_resultRDY`.
- The pipeline stalls on `busy` until `data_resultRDY` is seen.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_DIV  input  1  start pulse; sampled on the rising edge.
- data_operandA  input  WIDTH  dividend, two's complement.
- data_operandB  input  WIDTH  divisor, two's complement.
- data_result  output  WIDTH  quotient, registered.
- data_remainder  output  WIDTH  remainder, registered.
- data_exception  output  1  divide-by-zero or overflow flag, registered.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset:
  - Applied synchronously at any time, including mid-operation.
  - FSM goes to IDLE; counter = 0.
  - `data_result`, `data_remainder`, `data_exception`, `data_resultRDY`, `busy` all = 0.
  - Reset has priority over a coincident `ctrl_DIV`.
- States: IDLE, RUN, SIGN, DONE.
- IDLE / DONE with `ctrl_DIV` = 1:
  - Latch |A| into the dividend/quotient shift register and |B| into the divisor register.
  - Latch signA, and signA XOR signB.
  - Clear the (WIDTH+1)-bit partial remainder; counter = WIDTH.
  - Set `busy` = 1.
  - If B == 0: go straight to SIGN with the div-zero flag set.
  - Otherwise go to RUN.
- RUN, each cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − divisor, computed at WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and the quotient LSB = 1; else the LSB = 0.
  - Decrement the counter; at counter == 1 the next state is SIGN.
  - RUN lasts exactly WIDTH cycles.
- SIGN, one cycle:
  - Quotient is negated if the sign-XOR is set; truncation is toward zero.
  - Remainder is negated if signA; its sign follows the dividend.
  - Div-zero case: `data_result` = 0, `data_remainder` = A, `data_exception` = 1.
  - Overflow case (A = 0x80000000, B = 0xFFFFFFFF): `data_result` = 0x80000000, `data_remainder` = 0, `data_exception` = 1.
  - Otherwise `data_exception` = 0.
  - Outputs are registered on exit from SIGN.
  - `data_resultRDY` = 1 for exactly one cycle; `busy` = 0.
  - Next state is DONE.
- DONE: outputs hold their values until the next accepted start; `data_resultRDY` = 0.
- Latency:
  - Normal case: `data_resultRDY` is high in the cycle following WIDTH+1 edges after the start-sampling edge (WIDTH+2 edges total, i.e. 34 for WIDTH=32).
  - Div-zero: `data_resultRDY` follows 2 edges.
- `ctrl_DIV` while `busy` = 1 is ignored; the operation in flight is unaffected.
- Operand inputs are don't-care except on the start edge.
- `ctrl_DIV` in the same cycle that `data_resultRDY` is high (DONE entry) is accepted: outputs update and a new operation begins.
- The magnitude of 0x80000000 is handled as unsigned 2^31 in the internal WIDTH-bit registers; no sign bit is lost.

Test Plan:
- Basic: A=100, B=7, pulse `ctrl_DIV` → `data_resultRDY` pulse exactly 34 edges later, `data_result`=14, `data_remainder`=2, `data_exception`=0, `busy` high for 33 cycles.
- Signs: A=−100, B=7 → result −14 (0xFFFFFFF2), remainder −2. A=100, B=−7 → result −14, remainder 2. A=−100, B=−7 → result 14, remainder −2.
- Div-zero: A=55, B=0 → `data_resultRDY` after 2 edges, result 0, remainder 55, `data_exception`=1. Next op 9/3 → result 3, `data_exception` cleared.
- Overflow and extremes:
  - 0x80000000 / 0xFFFFFFFF → result 0x80000000, `data_exception`=1.
  - 0x80000000 / 2 → result 0xC0000000, remainder 0.
  - 0x7FFFFFFF / 1 → result 0x7FFFFFFF.
- Start while busy: start 1000/10, re-pulse `ctrl_DIV` with 5/5 at cycle 10 → single `data_resultRDY` at edge 34, result 100; no second pulse.
- Reset mid-operation: start 1000/10, assert `reset` at cycle 15 for 1 cycle → all outputs 0, `busy` 0, no `data_resultRDY`. Subsequent 8/2 completes normally with result 4. `ctrl_DIV` coincident with `reset` → ignored.

Source files
------------

// File: rtl/div_seq_if.sv
// Start/operand/result bundle shared by the multicycle divider and its driver.
// The master drives the start pulse and operands; the slave returns the result.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic [WIDTH-1:0] data_remainder;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_remainder, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_remainder, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/div_seq.sv
// Multicycle signed integer divider using a restoring shift-subtract datapath.
// Operands are reduced to magnitudes on start, divided for WIDTH cycles, and
// the signs are restored in a final fix-up cycle that registers the outputs.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic       clock,
   input logic       reset,
   div_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

   // Two's complement negation at WIDTH bits.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude as an unsigned WIDTH-bit value; the most negative number maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x);
      if (x[WIDTH-1]) begin
         return neg_w(x);
      end else begin
         return x;
      end
   endfunction

   state_t           state_r, state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] quo_r;        // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] rem_r;        // partial remainder; always below the divisor so WIDTH bits suffice
   logic [WIDTH-1:0] dvs_r;        // divisor magnitude
   logic             sign_a_r;
   logic             sign_q_r;
   logic             div_zero_r;
   logic             ovf_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] remainder_r;
   logic             exception_r;
   logic             rdy_r;
   logic             busy_r;

   logic             start_s;
   logic [WIDTH:0]   shift_rem_s;  // remainder shifted left with the next dividend bit, WIDTH+1 bits
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] fix_quo_s;
   logic [WIDTH-1:0] fix_rem_s;
   logic             fix_exc_s;

   // Start is only honoured while no operation is in flight.
   always_comb begin
      start_s = 1'b0;
      if (bus.ctrl_DIV && ((state_r == IDLE) || (state_r == DONE))) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
   end

   // Restoring step: shift in one dividend bit and trial-subtract the divisor.
   always_comb begin
      shift_rem_s = {rem_r, quo_r[WIDTH-1]};
      trial_s     = shift_rem_s - {1'b0, dvs_r};
   end

   // Sign fix-up of the final quotient/remainder, with the exceptional cases.
   always_comb begin
      fix_quo_s = quo_r;
      fix_rem_s = rem_r;
      fix_exc_s = 1'b0;
      if (div_zero_r) begin
         // quo_r still holds |A|, so restoring the dividend sign gives A back
         fix_quo_s = ZERO_W;
         fix_rem_s = sign_a_r ? neg_w(quo_r) : quo_r;
         fix_exc_s = 1'b1;
      end else begin
         // the overflow case falls out naturally as -(2^(WIDTH-1)) with remainder 0
         fix_quo_s = sign_q_r ? neg_w(quo_r) : quo_r;
         fix_rem_s = sign_a_r ? neg_w(rem_r) : rem_r;
         fix_exc_s = ovf_r;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (start_s) begin
               if (bus.data_operandB == ZERO_W) begin
                  state_next_s = SIGN;
               end else begin
                  state_next_s = RUN;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         RUN: begin
            if (cnt_r == CNT_ONE) begin
               state_next_s = SIGN;
            end else begin
               state_next_s = RUN;
            end
         end
         SIGN:    state_next_s = DONE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register; reset wins over a coincident start.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r       <= {CNT_W{1'b0}};
         quo_r       <= ZERO_W;
         rem_r       <= ZERO_W;
         dvs_r       <= ZERO_W;
         sign_a_r    <= 1'b0;
         sign_q_r    <= 1'b0;
         div_zero_r  <= 1'b0;
         ovf_r       <= 1'b0;
         result_r    <= ZERO_W;
         remainder_r <= ZERO_W;
         exception_r <= 1'b0;
         rdy_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               rdy_r <= 1'b0;
               if (start_s) begin
                  quo_r      <= mag_w(bus.data_operandA);
                  dvs_r      <= mag_w(bus.data_operandB);
                  rem_r      <= ZERO_W;
                  sign_a_r   <= bus.data_operandA[WIDTH-1];
                  sign_q_r   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                  div_zero_r <= (bus.data_operandB == ZERO_W);
                  ovf_r      <= (bus.data_operandA == MIN_W) && (bus.data_operandB == ONES_W);
                  cnt_r      <= CNT_INIT;
                  busy_r     <= 1'b1;
               end
            end
            RUN: begin
               if (trial_s[WIDTH] == 1'b0) begin
                  rem_r <= trial_s[WIDTH-1:0];
                  quo_r <= {quo_r[WIDTH-2:0], 1'b1};
               end else begin
                  rem_r <= shift_rem_s[WIDTH-1:0];
                  quo_r <= {quo_r[WIDTH-2:0], 1'b0};
               end
               cnt_r <= cnt_r - CNT_ONE;
            end
            SIGN: begin
               result_r    <= fix_quo_s;
               remainder_r <= fix_rem_s;
               exception_r <= fix_exc_s;
               rdy_r       <= 1'b1;
               busy_r      <= 1'b0;
            end
            default: begin
               rdy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_result    = result_r;
   assign bus.data_remainder = remainder_r;
   assign bus.data_exception = exception_r;
   assign bus.data_resultRDY = rdy_r;
   assign bus.busy           = busy_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands,
// compared against a plain-arithmetic signed division model.
module tb_div_seq;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   div_seq_if #(.WIDTH(32)) bus ();

   div_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop if something hangs despite the bounded waits.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: C-style signed division, truncating toward zero.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic e);
      int sa, sb;
      sa = a;
      sb = b;
      if (sb == 0) begin
         q = 32'd0; r = a; e = 1'b1;
      end else if (a == 32'h8000_0000 && sb == -1) begin
         q = 32'h8000_0000; r = 32'd0; e = 1'b1;
      end else begin
         q = sa / sb; r = sa % sb; e = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Runs one division starting at the current negedge. poke_at > 0 re-pulses
   // ctrl_DIV (5/5) after that many edges; tail > 0 then watches that many
   // cycles for stray completion pulses and for held outputs.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, input int tail);
      logic [31:0] eq, er;
      logic        ee;
      int          edges, busy_cnt, lat_exp, extra_rdy;
      ref_div(a, b, eq, er, ee);
      lat_exp = (b == 32'd0) ? 2 : 34;
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clock);
      edges = 1;
      @(negedge clock);
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      busy_cnt = 0;
      while (bus.data_resultRDY !== 1'b1 && edges < 100) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (edges == poke_at) begin
            bus.ctrl_DIV      = 1'b1;
            bus.data_operandA = 32'd5;
            bus.data_operandB = 32'd5;
         end else begin
            bus.ctrl_DIV = 1'b0;
         end
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
      bus.ctrl_DIV = 1'b0;
      check_eq({tag, " latency"}, edges, lat_exp);
      check_eq({tag, " result"}, bus.data_result, eq);
      check_eq({tag, " remainder"}, bus.data_remainder, er);
      check_eq({tag, " exception"}, {31'd0, bus.data_exception}, {31'd0, ee});
      check_eq({tag, " busy_low_at_rdy"}, {31'd0, bus.busy}, 32'd0);
      check_eq({tag, " busy_cycles"}, busy_cnt, lat_exp - 1);
      if (tail > 0) begin
         extra_rdy = 0;
         for (int i = 0; i < tail; i++) begin
            tick();
            if (bus.data_resultRDY === 1'b1) extra_rdy++;
         end
         check_eq({tag, " no_extra_rdy"}, extra_rdy, 0);
         check_eq({tag, " held_result"}, bus.data_result, eq);
         check_eq({tag, " held_remainder"}, bus.data_remainder, er);
      end
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          rdy_seen;
      n_checks = 0;
      n_fail   = 0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = 32'd0;
      bus.data_operandB = 32'd0;
      reset = 1'b1;
      @(negedge clock);
      tick();
      tick();
      reset = 1'b0;
      check_eq("reset result", bus.data_result, 32'd0);
      check_eq("reset remainder", bus.data_remainder, 32'd0);
      check_eq("reset exception", {31'd0, bus.data_exception}, 32'd0);
      check_eq("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
      check_eq("reset busy", {31'd0, bus.busy}, 32'd0);
      tick();

      // Basic and sign combinations
      run_op("basic", 32'd100, 32'd7, 0, 2);
      run_op("negA", -32'sd100, 32'd7, 0, 1);
      run_op("negB", 32'd100, -32'sd7, 0, 1);
      run_op("negAB", -32'sd100, -32'sd7, 0, 1);

      // Divide by zero, then a normal op clears the flag
      run_op("divzero", 32'd55, 32'd0, 0, 1);
      run_op("after_dz", 32'd9, 32'd3, 0, 1);

      // Extremes
      run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
      run_op("min_by_2", 32'h8000_0000, 32'd2, 0, 1);
      run_op("max_by_1", 32'h7FFF_FFFF, 32'd1, 0, 1);
      run_op("dz_min", 32'h8000_0000, 32'd0, 0, 1);

      // Start ignored while busy
      run_op("busy_repulse", 32'd1000, 32'd10, 10, 40);

      // Back-to-back: new start in the cycle the completion pulse is high
      run_op("b2b_first", 32'd77, 32'd5, 0, 0);
      run_op("b2b_second", -32'sd77, 32'd5, 0, 1);

      // Reset mid-operation
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd1000;
      bus.data_operandB = 32'd10;
      tick();
      bus.ctrl_DIV = 1'b0;
      for (int i = 1; i < 15; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("midrst result", bus.data_result, 32'd0);
      check_eq("midrst remainder", bus.data_remainder, 32'd0);
      check_eq("midrst exception", {31'd0, bus.data_exception}, 32'd0);
      check_eq("midrst busy", {31'd0, bus.busy}, 32'd0);
      rdy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.data_resultRDY === 1'b1) rdy_seen++;
         tick();
      end
      check_eq("midrst no_rdy", rdy_seen, 0);

      // Start coincident with reset is dropped
      reset             = 1'b1;
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd8;
      bus.data_operandB = 32'd2;
      tick();
      reset        = 1'b0;
      bus.ctrl_DIV = 1'b0;
      check_eq("rst_start busy", {31'd0, bus.busy}, 32'd0);
      rdy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.data_resultRDY === 1'b1) rdy_seen++;
         tick();
      end
      check_eq("rst_start no_rdy", rdy_seen, 0);
      run_op("after_rst", 32'd8, 32'd2, 0, 1);

      // Random operands, biased toward small and zero divisors
      for (int n = 0; n < 20; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 4))
            0: rb = $urandom;
            1: rb = $urandom_range(0, 32) - 16;
            2: rb = $urandom_range(0, 2000) - 1000;
            3: rb = 32'd0;
            default: rb = ra >> $urandom_range(1, 31);
         endcase
         if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 200) - 100;
         run_op("random", ra, rb, 0, (n % 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
